// File: rtl/csr_sched.sv
// csr_sched: sequences pipeline CSR read-modify-write accesses and trap entry writes onto a single-port CSR file.
// Optional CSR_SCHED_VECTORED_EN selects vectored trap handler addressing from mtvec mode bits.
module csr_sched #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic [1:0]        core_op,
    input  logic [11:0]       core_addr,
    input  logic [WORD_W-1:0] core_wdata,
    output logic              core_ready,
    output logic [WORD_W-1:0] core_rdata,
    output logic              core_illegal,
    input  logic              trap_req,
    input  logic [WORD_W-1:0] trap_pc,
    input  logic [WORD_W-1:0] trap_cause,
    input  logic [WORD_W-1:0] trap_tval,
    output logic              trap_done,
    output logic [WORD_W-1:0] trap_vector,
    output logic              csr_write,
    output logic [11:0]       csr_waddr,
    output logic [WORD_W-1:0] csr_wdata,
    output logic [11:0]       csr_raddr,
    input  logic [WORD_W-1:0] csr_rdata
);
    typedef enum logic [2:0] {IDLE, CORE_RD, CORE_WR, T_EPC, T_CAUSE, T_TVAL, T_VEC} state_t;
    state_t state;
    logic [1:0] op;
    logic [11:0] addr;
    logic [WORD_W-1:0] wdata, new_val, base;
    logic wr_en, ro_addr;
    always_comb begin
        new_val = op == 2'b01 ? wdata : op == 2'b10 ? csr_rdata | wdata : csr_rdata & ~wdata;
        wr_en = op == 2'b01 || wdata != '0;
        ro_addr = addr[11:10] == 2'b11;
        base = {csr_rdata[WORD_W-1:2], 2'b00};
    end
`ifdef CSR_SCHED_VECTORED_EN
    always_comb
        trap_vector = state != T_VEC ? '0 :
                      (csr_rdata[1:0] == 2'b01 && trap_cause[WORD_W-1]) ? base + {trap_cause[WORD_W-3:0], 2'b00} : base;
`else
    logic unused_mode;
    assign unused_mode = ^csr_rdata[1:0];
    always_comb trap_vector = state == T_VEC ? base : '0;
`endif
    // Outputs are registered for the state being entered, so every cycle starts from all-zero defaults.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op <= '0;
            addr <= '0;
            wdata <= '0;
            core_ready <= 1'b0;
            core_rdata <= '0;
            core_illegal <= 1'b0;
            trap_done <= 1'b0;
            csr_write <= 1'b0;
            csr_waddr <= '0;
            csr_wdata <= '0;
            csr_raddr <= '0;
        end else begin
            core_ready <= 1'b0;
            core_rdata <= '0;
            core_illegal <= 1'b0;
            trap_done <= 1'b0;
            csr_write <= 1'b0;
            csr_waddr <= '0;
            csr_wdata <= '0;
            csr_raddr <= '0;
            case (state)
                IDLE: begin
                    if (trap_req) begin
                        state <= T_EPC;
                        csr_write <= 1'b1;
                        csr_waddr <= 12'h341;
                        csr_wdata <= trap_pc;
                    end else if (core_req && core_op != 2'b00) begin
                        state <= CORE_RD;
                        op <= core_op;
                        addr <= core_addr;
                        wdata <= core_wdata;
                        csr_raddr <= core_addr;
                    end
                end
                CORE_RD: begin
                    state <= CORE_WR;
                    core_ready <= 1'b1;
                    core_rdata <= csr_rdata;
                    core_illegal <= wr_en && ro_addr;
                    csr_write <= wr_en && !ro_addr;
                    csr_waddr <= wr_en && !ro_addr ? addr : '0;
                    csr_wdata <= wr_en && !ro_addr ? new_val : '0;
                end
                T_EPC: begin
                    state <= T_CAUSE;
                    csr_write <= 1'b1;
                    csr_waddr <= 12'h342;
                    csr_wdata <= trap_cause;
                end
                T_CAUSE: begin
                    state <= T_TVAL;
                    csr_write <= 1'b1;
                    csr_waddr <= 12'h343;
                    csr_wdata <= trap_tval;
                end
                T_TVAL: begin
                    state <= T_VEC;
                    csr_raddr <= 12'h305;
                    trap_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
